multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
FSM that sequences a shared-memory RV32I datapath over multiple cycles: FETCH, DECODE, EXECUTE, MEM, WB.
Decodes opcode/fun3/fun7 from the instruction register and emits per-state datapath controls.
Runs a ready/enable handshake with a single unified memory port, with a timeout.
Sits between the instruction register/branch comparator and the PC, register file, ALU and memory interface.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting on mem_ready per access; 0 disables the timeout.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
opcode  input  7  IR[6:0]; stable from DECODE until instruction end
fun3  input  3  IR[14:12]
fun7  input  1  IR[30]
branch_taken  input  1  comparator result; valid in EXECUTE
mem_ready  input  1  memory access completes this cycle
mem_en  output  1  memory request; held until mem_ready
mem_we  output  1  store write strobe (MEM state only)
mem_addr_sel  output  1  0=PC, 1=ALU result
ir_write  output  1  latch instruction
pc_write  output  1  update PC
pc_src  output  2  00=PC+4, 01=PC+imm (branch/JAL), 10=ALU (JALR)
reg_write  output  1  register file write enable
rd_sel  output  2  00=ALU, 01=mem data, 10=PC+4
operand_b  output  1  0=rs2, 1=immediate
imm_sel  output  2  00=I, 01=S, 10=B, 11=J
alu_control  output  4  ALU operation code
instr_done  output  1  one-cycle retire pulse
illegal_instr  output  1  one-cycle pulse on unsupported opcode
mem_fault  output  1  one-cycle pulse on timeout

Behaviour:
- While rst=1: state<=FETCH, timeout counter<=0, all outputs 0. On the first cycle after release, FETCH is active with mem_en=1.
- Outputs are combinational from the registered state plus the instruction class registered in DECODE. No output depends on mem_ready, except ir_write and the exits gated by it.
- FETCH: mem_en=1, mem_addr_sel=0. If mem_ready=1: ir_write=1 and go to DECODE. Otherwise stay in FETCH.
- DECODE: classify the instruction as R(0110011), I-ALU(0010011), LOAD(0000011), STORE(0100011), BRANCH(1100011), JAL(1101111) or JALR(1100111), and register the class.
  - Any other opcode: illegal_instr=1, pc_write=1, pc_src=00, instr_done=0, go to FETCH.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - R: operand_b=0, alu_control from fun3/fun7.
  - I-ALU: operand_b=1, imm_sel=00. fun7 is honoured only for fun3=101 (SRLI/SRAI); otherwise ADD/SLT/etc.
  - LOAD/JALR: ADD, operand_b=1, imm_sel=00.
  - STORE: ADD, operand_b=1, imm_sel=01.
  - BRANCH: imm_sel=10, alu_control SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU. pc_write=1, pc_src=branch_taken?01:00, instr_done=1, go to FETCH.
  - LOAD/STORE go to MEM; all other classes go to WB.
- MEM: mem_en=1, mem_addr_sel=1, mem_we=1 for STORE only.
  - On mem_ready: LOAD goes to WB; STORE sets pc_write=1, pc_src=00, instr_done=1, goes to FETCH.
- WB: reg_write=1, rd_sel 00 for R/I, 01 for LOAD, 10 for JAL/JALR. pc_write=1, pc_src 00 (R/I/LOAD), 01 (JAL, imm_sel=11), 10 (JALR). instr_done=1, go to FETCH.
- PC updates only in the final state, so PC+4 and PC+imm always use the current instruction's PC.
- ALU codes: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001. Defaults are ADD and all enables 0.
- Timeout counter: increments each cycle in FETCH/MEM without mem_ready and clears on any state change.
  - On reaching MEM_TIMEOUT in FETCH: mem_fault=1, counter cleared, stay in FETCH (retry).
  - On reaching MEM_TIMEOUT in MEM: mem_fault=1, no reg_write and no mem_we beyond that cycle, pc_write=1, pc_src=00, instr_done=0, go to FETCH.
  - mem_ready on the timeout cycle wins: normal completion, no fault.
- Latency with zero-wait memory: BRANCH 3 cycles; R/I/JAL/JALR/STORE 4; LOAD 5.
- rst mid-instruction aborts it: no writes occur in the reset cycle.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXECUTE, MEM, WB);
  - opcode constants;
  - ALU code constants;
  - imm_sel, rd_sel and pc_src encodings;
  - instruction-class enum.
- One sub-module, alu_op_decoder: combinational mapping of class/fun3/fun7 to alu_control, covering R, I-ALU and branch compare.

Test Plan:
- rst=1 for 2 cycles mid-LOAD in MEM -> all outputs 0 in the reset cycles; next cycle FETCH with mem_en=1 and no reg_write seen.
- ADD R-type (0110011, fun3=000, fun7=0), mem_ready=1 -> ir_write@c1, EXECUTE alu_control=0000, WB reg_write=1 rd_sel=00 pc_src=00, instr_done@c4.
- SUB with fun7=1 -> alu_control=0001. SRAI (0010011, fun3=101, fun7=1) -> 0111. ADDI with fun7=1 -> 0000.
- LW with mem_ready delayed 3 cycles in MEM -> mem_en held 4 cycles, then WB rd_sel=01, total 8 cycles.
- BEQ with branch_taken=1 -> alu_control=0001, pc_write=1 pc_src=01, instr_done in EXECUTE (3 cycles). Same with branch_taken=0 -> pc_src=00.
- mem_ready held 0 with MEM_TIMEOUT=16 -> mem_fault pulse after 16 FETCH cycles, stays in FETCH.
- Opcode 0110111 -> illegal_instr pulse in DECODE, pc_write=1, no instr_done.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I controller: states, opcodes,
// ALU codes, datapath mux selects and the instruction class decoded in DECODE.
package ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWb
  } state_e;

  typedef enum logic [2:0] {
    ClsIllegal,
    ClsR,
    ClsIAlu,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJal,
    ClsJalr
  } instr_class_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluSll  = 4'b0010;
  localparam logic [3:0] AluSlt  = 4'b0011;
  localparam logic [3:0] AluSltu = 4'b0100;
  localparam logic [3:0] AluXor  = 4'b0101;
  localparam logic [3:0] AluSrl  = 4'b0110;
  localparam logic [3:0] AluSra  = 4'b0111;
  localparam logic [3:0] AluOr   = 4'b1000;
  localparam logic [3:0] AluAnd  = 4'b1001;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [1:0] RdAlu = 2'b00;
  localparam logic [1:0] RdMem = 2'b01;
  localparam logic [1:0] RdPc4 = 2'b10;

  localparam logic [1:0] PcPlus4 = 2'b00;
  localparam logic [1:0] PcImm   = 2'b01;
  localparam logic [1:0] PcAlu   = 2'b10;

  function automatic instr_class_e classify(logic [6:0] op);
    instr_class_e cls;
    case (op)
      OpR:      cls = ClsR;
      OpIAlu:   cls = ClsIAlu;
      OpLoad:   cls = ClsLoad;
      OpStore:  cls = ClsStore;
      OpBranch: cls = ClsBranch;
      OpJal:    cls = ClsJal;
      OpJalr:   cls = ClsJalr;
      default:  cls = ClsIllegal;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: IR fields and comparator in, datapath
// controls and unified memory handshake out.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] fun3;
  logic       fun7;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_en;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic [1:0] rd_sel;
  logic       operand_b;
  logic [1:0] imm_sel;
  logic [3:0] alu_control;
  logic       instr_done;
  logic       illegal_instr;
  logic       mem_fault;

  modport master (
    input  opcode, fun3, fun7, branch_taken, mem_ready,
    output mem_en, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write, rd_sel,
           operand_b, imm_sel, alu_control, instr_done, illegal_instr, mem_fault
  );

  modport slave (
    output opcode, fun3, fun7, branch_taken, mem_ready,
    input  mem_en, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write, rd_sel,
           operand_b, imm_sel, alu_control, instr_done, illegal_instr, mem_fault
  );
endinterface

// File: rtl/alu_op_decoder.sv
// Maps instruction class plus fun3/fun7 to the ALU operation code for R-type,
// I-type ALU and branch compares; everything else adds.
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  instr_class_e cls_i,
  input  logic [2:0]   fun3_i,
  input  logic         fun7_i,
  output logic [3:0]   alu_control_o
);

  always_comb begin
    alu_control_o = AluAdd;
    unique case (cls_i)
      ClsR, ClsIAlu: begin
        case (fun3_i)
          // Immediate ADDI has no SUB form; IR[30] is part of the immediate there.
          3'b000:  alu_control_o = (cls_i == ClsR && fun7_i) ? AluSub : AluAdd;
          3'b001:  alu_control_o = AluSll;
          3'b010:  alu_control_o = AluSlt;
          3'b011:  alu_control_o = AluSltu;
          3'b100:  alu_control_o = AluXor;
          3'b101:  alu_control_o = fun7_i ? AluSra : AluSrl;
          3'b110:  alu_control_o = AluOr;
          default: alu_control_o = AluAnd;
        endcase
      end
      ClsBranch: begin
        case (fun3_i[2:1])
          2'b00:   alu_control_o = AluSub;
          2'b10:   alu_control_o = AluSlt;
          2'b11:   alu_control_o = AluSltu;
          default: alu_control_o = AluAdd;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM (FETCH/DECODE/EXECUTE/MEM/WB) with a unified memory
// handshake and a per-access wait timeout.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_controller_if.master bus
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e          state_q, state_d;
  instr_class_e    class_q, class_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout;
  logic [3:0]      alu_dec;

  logic       mem_en, mem_we, mem_addr_sel, ir_write, pc_write, reg_write;
  logic       operand_b, instr_done, illegal_instr, mem_fault;
  logic [1:0] pc_src, rd_sel, imm_sel;
  logic [3:0] alu_control;

  alu_op_decoder u_alu_dec (
    .cls_i         (class_q),
    .fun3_i        (bus.fun3),
    .fun7_i        (bus.fun7),
    .alu_control_o (alu_dec)
  );

  // Fires on the MEM_TIMEOUT-th consecutive waiting cycle; a ready in that cycle wins.
  assign timeout = (MEM_TIMEOUT != 0) && (32'(cnt_q) == MEM_TIMEOUT - 1) && !bus.mem_ready;

  always_comb begin
    state_d       = state_q;
    class_d       = class_q;
    cnt_d         = '0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PcPlus4;
    reg_write     = 1'b0;
    rd_sel        = RdAlu;
    operand_b     = 1'b0;
    imm_sel       = ImmI;
    alu_control   = AluAdd;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    mem_fault     = 1'b0;

    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          mem_en = 1'b1;
          if (bus.mem_ready) begin
            ir_write = 1'b1;
            state_d  = StDecode;
          end else if (timeout) begin
            mem_fault = 1'b1;
          end
        end
        StDecode: begin
          class_d = classify(bus.opcode);
          if (class_d == ClsIllegal) begin
            illegal_instr = 1'b1;
            pc_write      = 1'b1;
            state_d       = StFetch;
          end else begin
            state_d = StExecute;
          end
        end
        StExecute: begin
          alu_control = alu_dec;
          state_d     = StWb;
          unique case (class_q)
            ClsIAlu, ClsLoad, ClsJalr: operand_b = 1'b1;
            ClsStore: begin
              operand_b = 1'b1;
              imm_sel   = ImmS;
            end
            ClsBranch: begin
              imm_sel    = ImmB;
              pc_write   = 1'b1;
              pc_src     = bus.branch_taken ? PcImm : PcPlus4;
              instr_done = 1'b1;
            end
            ClsJal:  imm_sel = ImmJ;
            default: ;
          endcase
          if (class_q == ClsBranch || class_q == ClsIllegal) begin
            state_d = StFetch;
          end else if (class_q == ClsLoad || class_q == ClsStore) begin
            state_d = StMem;
          end
        end
        StMem: begin
          mem_en       = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (class_q == ClsStore);
          if (bus.mem_ready) begin
            if (class_q == ClsStore) begin
              pc_write   = 1'b1;
              instr_done = 1'b1;
              state_d    = StFetch;
            end else begin
              state_d = StWb;
            end
          end else if (timeout) begin
            // Abandon the access: skip the PC past it without retiring.
            mem_fault = 1'b1;
            pc_write  = 1'b1;
            state_d   = StFetch;
          end
        end
        StWb: begin
          reg_write  = 1'b1;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
          unique case (class_q)
            ClsLoad: rd_sel = RdMem;
            ClsJal: begin
              rd_sel  = RdPc4;
              pc_src  = PcImm;
              imm_sel = ImmJ;
            end
            ClsJalr: begin
              rd_sel = RdPc4;
              pc_src = PcAlu;
            end
            default: ;
          endcase
        end
        default: state_d = StFetch;
      endcase

      if ((state_q == StFetch || state_q == StMem) && (state_d == state_q) &&
          !bus.mem_ready && !timeout && (MEM_TIMEOUT != 0)) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      class_q <= ClsIllegal;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_en        = mem_en;
  assign bus.mem_we        = mem_we;
  assign bus.mem_addr_sel  = mem_addr_sel;
  assign bus.ir_write      = ir_write;
  assign bus.pc_write      = pc_write;
  assign bus.pc_src        = pc_src;
  assign bus.reg_write     = reg_write;
  assign bus.rd_sel        = rd_sel;
  assign bus.operand_b     = operand_b;
  assign bus.imm_sel       = imm_sel;
  assign bus.alu_control   = alu_control;
  assign bus.instr_done    = instr_done;
  assign bus.illegal_instr = illegal_instr;
  assign bus.mem_fault     = mem_fault;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a table of zero-wait instructions plus
// hand sequences for reset abort, memory wait states, timeouts and illegal opcodes.
module tb_multicycle_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multicycle_controller_if bus_if ();

  multicycle_controller #(
    .MEM_TIMEOUT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [6:0] opcode;
    logic [2:0] fun3;
    logic       fun7;
    logic       taken;
    logic [3:0] exp_alu;
    int         exp_cycles;
    logic [1:0] exp_pc_src;
    logic [1:0] exp_rd_sel;
    logic       exp_reg_write;
    logic       exp_mem_we;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] outs();
    return {bus_if.mem_en, bus_if.mem_we, bus_if.mem_addr_sel, bus_if.ir_write,
            bus_if.pc_write, bus_if.pc_src, bus_if.reg_write, bus_if.rd_sel,
            bus_if.operand_b, bus_if.imm_sel, bus_if.alu_control, bus_if.instr_done,
            bus_if.illegal_instr, bus_if.mem_fault};
  endfunction

  task automatic do_reset();
    rst              = 1'b1;
    bus_if.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         cyc;
    logic [3:0] alu_exe;
    logic       ir1, seen_we, rw, pw;
    logic [1:0] pcs, rds;
    cyc     = 0;
    alu_exe = 4'hf;
    ir1     = 1'b0;
    seen_we = 1'b0;
    rw      = 1'b0;
    pw      = 1'b0;
    pcs     = 2'b11;
    rds     = 2'b11;
    bus_if.opcode       = v.opcode;
    bus_if.fun3         = v.fun3;
    bus_if.fun7         = v.fun7;
    bus_if.branch_taken = v.taken;
    bus_if.mem_ready    = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) ir1 = bus_if.ir_write;
      if (c == 3) alu_exe = bus_if.alu_control;
      if (bus_if.mem_we) seen_we = 1'b1;
      if (bus_if.instr_done || bus_if.illegal_instr) begin
        cyc = c;
        pcs = bus_if.pc_src;
        rds = bus_if.rd_sel;
        rw  = bus_if.reg_write;
        pw  = bus_if.pc_write;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check($sformatf("v%0d ir_write_c1", idx), ir1, 1'b1);
    check($sformatf("v%0d cycles", idx), cyc, v.exp_cycles);
    check($sformatf("v%0d alu_control", idx), alu_exe, v.exp_alu);
    check($sformatf("v%0d pc_src", idx), pcs, v.exp_pc_src);
    check($sformatf("v%0d pc_write", idx), pw, 1'b1);
    check($sformatf("v%0d rd_sel", idx), rds, v.exp_rd_sel);
    check($sformatf("v%0d reg_write", idx), rw, v.exp_reg_write);
    check($sformatf("v%0d mem_we_seen", idx), seen_we, v.exp_mem_we);
  endtask

  initial begin
    int         first, nfault, memcnt, done_cyc;
    logic       flag_a, flag_b, flag_c;
    logic [1:0] sel;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus_if.opcode       = 7'd0;
    bus_if.fun3         = 3'd0;
    bus_if.fun7         = 1'b0;
    bus_if.branch_taken = 1'b0;
    bus_if.mem_ready    = 1'b0;

    //         opcode      f3     f7    tk    alu    cyc pc_src rd_sel rw   we
    vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4'h0, 4, 2'b00, 2'b00, 1'b1, 1'b0}; // ADD
    vecs[1]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4'h1, 4, 2'b00, 2'b00, 1'b1, 1'b0}; // SUB
    vecs[2]  = '{7'b0110011, 3'b101, 1'b1, 1'b0, 4'h7, 4, 2'b00, 2'b00, 1'b1, 1'b0}; // SRA
    vecs[3]  = '{7'b0010011, 3'b101, 1'b1, 1'b0, 4'h7, 4, 2'b00, 2'b00, 1'b1, 1'b0}; // SRAI
    vecs[4]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4'h0, 4, 2'b00, 2'b00, 1'b1, 1'b0}; // ADDI
    vecs[5]  = '{7'b0010011, 3'b101, 1'b0, 1'b0, 4'h6, 4, 2'b00, 2'b00, 1'b1, 1'b0}; // SRLI
    vecs[6]  = '{7'b0110011, 3'b100, 1'b0, 1'b0, 4'h5, 4, 2'b00, 2'b00, 1'b1, 1'b0}; // XOR
    vecs[7]  = '{7'b0010011, 3'b111, 1'b1, 1'b0, 4'h9, 4, 2'b00, 2'b00, 1'b1, 1'b0}; // ANDI
    vecs[8]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 4'h0, 5, 2'b00, 2'b01, 1'b1, 1'b0}; // LW
    vecs[9]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4'h0, 4, 2'b00, 2'b00, 1'b0, 1'b1}; // SW
    vecs[10] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 4'h1, 3, 2'b01, 2'b00, 1'b0, 1'b0}; // BEQ t
    vecs[11] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 4'h1, 3, 2'b00, 2'b00, 1'b0, 1'b0}; // BEQ nt
    vecs[12] = '{7'b1100011, 3'b100, 1'b0, 1'b1, 4'h3, 3, 2'b01, 2'b00, 1'b0, 1'b0}; // BLT
    vecs[13] = '{7'b1100011, 3'b111, 1'b0, 1'b0, 4'h4, 3, 2'b00, 2'b00, 1'b0, 1'b0}; // BGEU
    vecs[14] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4'h0, 4, 2'b01, 2'b10, 1'b1, 1'b0}; // JAL
    vecs[15] = '{7'b1100111, 3'b000, 1'b0, 1'b0, 4'h0, 4, 2'b10, 2'b10, 1'b1, 1'b0}; // JALR

    // Power-on reset: outputs quiet, then FETCH requests memory.
    @(posedge clk);
    @(negedge clk);
    check("por outputs", outs(), 20'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("por fetch mem_en", {bus_if.mem_en, bus_if.mem_addr_sel}, 2'b10);

    do_reset();
    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Reset while a LOAD waits in MEM.
    do_reset();
    bus_if.opcode = 7'b0000011;
    bus_if.fun3   = 3'b010;
    for (int c = 1; c <= 4; c++) begin
      bus_if.mem_ready = (c == 1);
      @(negedge clk);
      if (c == 4) check("rst pre mem", {bus_if.mem_en, bus_if.mem_addr_sel}, 2'b11);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst cycle1 outputs", outs(), 20'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst cycle2 outputs", outs(), 20'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst release fetch", {bus_if.mem_en, bus_if.mem_addr_sel, bus_if.reg_write}, 3'b100);

    // LOAD with three wait states in MEM.
    do_reset();
    bus_if.opcode = 7'b0000011;
    bus_if.fun3   = 3'b010;
    memcnt   = 0;
    done_cyc = 0;
    sel      = 2'b11;
    for (int c = 1; c <= 20; c++) begin
      bus_if.mem_ready = (c == 1) || (c >= 7);
      @(negedge clk);
      if (bus_if.mem_en && bus_if.mem_addr_sel) memcnt++;
      if (bus_if.instr_done) begin
        done_cyc = c;
        sel      = bus_if.rd_sel;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("lw wait mem_en cycles", memcnt, 4);
    check("lw wait total cycles", done_cyc, 8);
    check("lw wait rd_sel", sel, 2'b01);

    // FETCH timeout: fault on the 16th idle cycle, then keep retrying.
    do_reset();
    first  = 0;
    nfault = 0;
    flag_a = 1'b0;
    flag_b = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      bus_if.mem_ready = 1'b0;
      @(negedge clk);
      if (bus_if.mem_fault) begin
        nfault++;
        if (first == 0) first = c;
      end
      if (c == 17) flag_a = bus_if.mem_en && !bus_if.mem_addr_sel;
      if (bus_if.ir_write) flag_b = 1'b1;
      @(posedge clk);
      #1;
    end
    check("fetch timeout cycle", first, 16);
    check("fetch timeout count", nfault, 1);
    check("fetch retry mem_en", flag_a, 1'b1);
    check("fetch timeout ir_write", flag_b, 1'b0);

    // Ready arriving on the timeout cycle completes normally.
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      bus_if.mem_ready = (c == 16);
      @(negedge clk);
      if (c == 16) begin
        check("ready wins ir_write", bus_if.ir_write, 1'b1);
        check("ready wins no fault", bus_if.mem_fault, 1'b0);
      end
      @(posedge clk);
      #1;
    end

    // STORE timing out in MEM: fault, PC advance, no retire, back to FETCH.
    do_reset();
    bus_if.opcode = 7'b0100011;
    bus_if.fun3   = 3'b010;
    first  = 0;
    flag_a = 1'b0;
    flag_b = 1'b0;
    flag_c = 1'b0;
    sel    = 2'b11;
    for (int c = 1; c <= 21; c++) begin
      bus_if.mem_ready = (c == 1);
      @(negedge clk);
      if (first != 0 && c == first + 1)
        flag_c = bus_if.mem_en && !bus_if.mem_addr_sel && !bus_if.mem_we;
      if (bus_if.mem_fault && first == 0) begin
        first  = c;
        flag_a = bus_if.pc_write;
        sel    = bus_if.pc_src;
      end
      if (bus_if.instr_done) flag_b = 1'b1;
      @(posedge clk);
      #1;
    end
    check("mem timeout cycle", first, 19);
    check("mem timeout pc_write", flag_a, 1'b1);
    check("mem timeout pc_src", sel, 2'b00);
    check("mem timeout no retire", flag_b, 1'b0);
    check("mem timeout back to fetch", flag_c, 1'b1);

    // Unsupported opcode (LUI) is flagged in DECODE.
    do_reset();
    bus_if.opcode    = 7'b0110111;
    bus_if.mem_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 2) begin
        check("illegal pulse", bus_if.illegal_instr, 1'b1);
        check("illegal pc_write", bus_if.pc_write, 1'b1);
        check("illegal pc_src", bus_if.pc_src, 2'b00);
        check("illegal no done", bus_if.instr_done, 1'b0);
      end
      if (c == 3) begin
        check("illegal pulse ends", bus_if.illegal_instr, 1'b0);
        check("illegal refetch", {bus_if.mem_en, bus_if.mem_addr_sel}, 2'b10);
      end
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
